// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with synchronous preload, same-cycle carry/borrow
// for cascading, and a two-digit BCD view held in its own registers.
module mod_updown_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 7,
    parameter int INIT    = 0
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             co,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] LP_MAX       = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_INIT      = WIDTH'(INIT);
    localparam logic [3:0]       LP_MAX_TENS  = 4'((MODULUS - 1) / 10);
    localparam logic [3:0]       LP_MAX_ONES  = 4'((MODULUS - 1) % 10);
    localparam logic [3:0]       LP_INIT_TENS = 4'(INIT / 10);
    localparam logic [3:0]       LP_INIT_ONES = 4'(INIT % 10);

    logic [WIDTH-1:0] r_cnt;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_load_err;

    logic             w_load_ok;
    logic             w_at_max;
    logic             w_at_zero;
    logic [3:0]       w_ld_tens;
    logic [3:0]       w_ld_ones;

    assign w_load_ok = 32'(load_val) < 32'(MODULUS);
    assign w_at_max  = (r_cnt == LP_MAX);
    assign w_at_zero = (r_cnt == '0);

    // Preload digits found by threshold compare; only meaningful when w_load_ok.
    always_comb begin
        w_ld_tens = '0;
        for (int i = 1; i < 10; i++) begin
            if (32'(load_val) >= 32'(10 * i)) begin
                w_ld_tens = 4'(i);
            end
        end
        w_ld_ones = 4'(32'(load_val) - (32'(w_ld_tens) * 32'd10));
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_cnt      <= LP_INIT;
            r_tens     <= LP_INIT_TENS;
            r_ones     <= LP_INIT_ONES;
            r_load_err <= 1'b0;
        end else if (load) begin
            if (w_load_ok) begin
                r_cnt      <= load_val;
                r_tens     <= w_ld_tens;
                r_ones     <= w_ld_ones;
                r_load_err <= 1'b0;
            end else begin
                r_cnt      <= '0;
                r_tens     <= '0;
                r_ones     <= '0;
                r_load_err <= 1'b1;
            end
        end else if (en) begin
            r_load_err <= 1'b0;
            if (up_dn) begin
                if (w_at_max) begin
                    r_cnt  <= '0;
                    r_tens <= '0;
                    r_ones <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_ones == 4'd9) begin
                        r_ones <= '0;
                        r_tens <= r_tens + 1'b1;
                    end else begin
                        r_ones <= r_ones + 1'b1;
                    end
                end
            end else begin
                if (w_at_zero) begin
                    r_cnt  <= LP_MAX;
                    r_tens <= LP_MAX_TENS;
                    r_ones <= LP_MAX_ONES;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_ones == 4'd0) begin
                        r_ones <= 4'd9;
                        r_tens <= r_tens - 1'b1;
                    end else begin
                        r_ones <= r_ones - 1'b1;
                    end
                end
            end
        end else begin
            r_load_err <= 1'b0;
        end
    end

    // Zero-latency carry so the next stage steps on the same edge this one wraps.
    assign co = en & ~load & ~rst & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

    assign cnt      = r_cnt;
    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed and randomized checks of mod_updown_counter, including an
// hours:minutes:seconds cascade.
module tb_mod_updown_counter;

    logic       clk_1;
    logic       rst;
    logic       up_dn;
    logic       en_s, ld_s, ld_m, ld_h;
    logic [6:0] lv_s, lv_m;
    logic [4:0] lv_h;

    logic [6:0] cnt_s, cnt_m;
    logic [4:0] cnt_h;
    logic [3:0] tens_s, ones_s, tens_m, ones_m, tens_h, ones_h;
    logic       co_s, co_m, co_h;
    logic       err_s, err_m, err_h;

    int n_chk = 0;
    int n_err = 0;

    mod_updown_counter #(.MODULUS(60), .WIDTH(7), .INIT(0)) u_sec (
        .clk_1(clk_1), .rst(rst), .en(en_s), .up_dn(up_dn), .load(ld_s), .load_val(lv_s),
        .cnt(cnt_s), .bcd_tens(tens_s), .bcd_ones(ones_s), .co(co_s), .load_err(err_s));

    mod_updown_counter #(.MODULUS(60), .WIDTH(7), .INIT(5)) u_min (
        .clk_1(clk_1), .rst(rst), .en(co_s), .up_dn(up_dn), .load(ld_m), .load_val(lv_m),
        .cnt(cnt_m), .bcd_tens(tens_m), .bcd_ones(ones_m), .co(co_m), .load_err(err_m));

    mod_updown_counter #(.MODULUS(24), .WIDTH(5), .INIT(0)) u_hr (
        .clk_1(clk_1), .rst(rst), .en(co_m), .up_dn(up_dn), .load(ld_h), .load_val(lv_h),
        .cnt(cnt_h), .bcd_tens(tens_h), .bcd_ones(ones_h), .co(co_h), .load_err(err_h));

    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        int exp_dn[4];
        int m;
        logic m_err;
        logic e_co;

        rst = 1'b1; up_dn = 1'b1; en_s = 1'b0;
        ld_s = 1'b0; ld_m = 1'b0; ld_h = 1'b0;
        lv_s = '0; lv_m = '0; lv_h = '0;

        // Reset
        tick(); tick();
        chk("rst_cnt", 32'(cnt_s), 0);
        chk("rst_tens", 32'(tens_s), 0);
        chk("rst_ones", 32'(ones_s), 0);
        chk("rst_err", 32'(err_s), 0);
        chk("rst_min_init", 32'(cnt_m), 5);
        chk("rst_min_ones", 32'(ones_m), 5);

        // Up-count through a full wrap
        rst = 1'b0; en_s = 1'b1; up_dn = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            #1;
            chk("up_cnt", 32'(cnt_s), 32'(i % 60));
            chk("up_tens", 32'(tens_s), 32'((i % 60) / 10));
            chk("up_ones", 32'(ones_s), 32'((i % 60) % 10));
            chk("up_co", 32'(co_s), 32'(i == 59));
            tick();
        end

        // Down-count wrap from 1
        ld_s = 1'b1; lv_s = 7'd1; up_dn = 1'b0;
        #1;
        chk("dn_load_co", 32'(co_s), 0);
        tick();
        ld_s = 1'b0;
        exp_dn = '{1, 0, 59, 58};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("dn_cnt", 32'(cnt_s), 32'(exp_dn[k]));
            chk("dn_tens", 32'(tens_s), 32'(exp_dn[k] / 10));
            chk("dn_ones", 32'(ones_s), 32'(exp_dn[k] % 10));
            chk("dn_co", 32'(co_s), 32'(exp_dn[k] == 0));
            tick();
        end

        // Preload and out-of-range preload, with cnt parked at terminal count
        en_s = 1'b0; ld_s = 1'b1; lv_s = 7'd59;
        tick();
        en_s = 1'b1; up_dn = 1'b1; lv_s = 7'd42;
        #1;
        chk("ld42_co", 32'(co_s), 0);
        tick();
        chk("ld42_cnt", 32'(cnt_s), 42);
        chk("ld42_tens", 32'(tens_s), 4);
        chk("ld42_ones", 32'(ones_s), 2);
        chk("ld42_err", 32'(err_s), 0);
        lv_s = 7'd75;
        #1;
        chk("ld75_co", 32'(co_s), 0);
        tick();
        chk("ld75_cnt", 32'(cnt_s), 0);
        chk("ld75_tens", 32'(tens_s), 0);
        chk("ld75_ones", 32'(ones_s), 0);
        chk("ld75_err", 32'(err_s), 1);
        ld_s = 1'b0; en_s = 1'b0;
        tick();
        chk("ld75_err_clr", 32'(err_s), 0);
        chk("ld75_hold", 32'(cnt_s), 0);

        // Hold and priority
        ld_s = 1'b1; lv_s = 7'd33;
        tick();
        ld_s = 1'b0;
        repeat (10) tick();
        chk("hold_cnt", 32'(cnt_s), 33);
        chk("hold_tens", 32'(tens_s), 3);
        ld_s = 1'b1; lv_s = 7'd10; en_s = 1'b1; up_dn = 1'b1;
        tick();
        chk("ld_over_en", 32'(cnt_s), 10);
        en_s = 1'b0; lv_s = 7'd59;
        tick();
        rst = 1'b1; lv_s = 7'd20; en_s = 1'b1;
        #1;
        chk("rst_co", 32'(co_s), 0);
        tick();
        chk("rst_over_ld", 32'(cnt_s), 0);
        chk("rst_min_cnt", 32'(cnt_m), 5);
        rst = 1'b0; ld_s = 1'b0; en_s = 1'b0;

        // Cascade 23:59:58 -> 23:59:59 -> 00:00:00 -> 00:00:01
        ld_s = 1'b1; ld_m = 1'b1; ld_h = 1'b1;
        lv_s = 7'd58; lv_m = 7'd59; lv_h = 5'd23;
        tick();
        ld_s = 1'b0; ld_m = 1'b0; ld_h = 1'b0;
        en_s = 1'b1; up_dn = 1'b1;
        #1;
        chk("cas0_sec", 32'(cnt_s), 58);
        chk("cas0_co_s", 32'(co_s), 0);
        chk("cas0_co_m", 32'(co_m), 0);
        tick();
        chk("cas1_sec", 32'(cnt_s), 59);
        chk("cas1_min", 32'(cnt_m), 59);
        chk("cas1_hr", 32'(cnt_h), 23);
        chk("cas1_hr_tens", 32'(tens_h), 2);
        chk("cas1_co_s", 32'(co_s), 1);
        chk("cas1_co_m", 32'(co_m), 1);
        chk("cas1_co_h", 32'(co_h), 1);
        tick();
        chk("cas2_sec", 32'(cnt_s), 0);
        chk("cas2_min", 32'(cnt_m), 0);
        chk("cas2_hr", 32'(cnt_h), 0);
        chk("cas2_hr_bcd", 32'({tens_h, ones_h}), 0);
        chk("cas2_co_h", 32'(co_h), 0);
        tick();
        chk("cas3_sec", 32'(cnt_s), 1);
        chk("cas3_min", 32'(cnt_m), 0);
        chk("cas3_hr", 32'(cnt_h), 0);

        // Random stimulus against a reference model
        m = 1;
        m_err = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            en_s  = 1'($urandom_range(0, 1));
            up_dn = 1'($urandom_range(0, 1));
            ld_s  = ($urandom_range(0, 15) == 0);
            lv_s  = 7'($urandom_range(0, 127));
            #1;
            e_co = en_s & ~ld_s & ((up_dn & (m == 59)) | (~up_dn & (m == 0)));
            chk("rnd_co", 32'(co_s), 32'(e_co));
            if (ld_s) begin
                if (int'(lv_s) < 60) begin
                    m = int'(lv_s);
                    m_err = 1'b0;
                end else begin
                    m = 0;
                    m_err = 1'b1;
                end
            end else begin
                m_err = 1'b0;
                if (en_s) m = up_dn ? ((m == 59) ? 0 : m + 1) : ((m == 0) ? 59 : m - 1);
            end
            tick();
            chk("rnd_cnt", 32'(cnt_s), 32'(m));
            chk("rnd_tens", 32'(tens_s), 32'(m / 10));
            chk("rnd_ones", 32'(ones_s), 32'(m % 10));
            chk("rnd_err", 32'(err_s), 32'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
